// File: rtl/switch_port_ctrl_if.sv
// Byte ingress and FIFO egress bundle for switch_port_ctrl.
// Handshake: upstream presents data_in/data_status; the byte transfers on a
// posedge where busy==0 (busy is the inverse of ready and upstream must hold
// data_in/data_status stable while busy==1). write_enb is a one-hot write
// strobe qualifying data_out; the FIFO has no back-pressure other than fifo_full.
interface switch_port_ctrl_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8
);
  logic [DATA_W-1:0]    data_in;
  logic                 data_status;
  logic                 busy;
  logic [NUM_PORTS-1:0] fifo_full;
  logic                 hold;
  logic [NUM_PORTS-1:0] write_enb;
  logic [DATA_W-1:0]    data_out;

  modport master (
    output data_in, data_status, fifo_full, hold,
    input  busy, write_enb, data_out
  );

  modport slave (
    input  data_in, data_status, fifo_full, hold,
    output busy, write_enb, data_out
  );
endinterface

// File: rtl/switch_port_ctrl.sv
// Ingress port controller: decodes a packet header against NUM_PORTS port
// addresses, steers header/payload/parity bytes into the selected FIFO,
// drops unmatched packets and (optionally) checks packet parity.
// Optional feature macro: SWITCH_PARITY_CHECK_EN (parity accumulation,
// CHECK state and parity_err). Undefined: parity_err is tied low and the
// controller returns to IDLE right after writing the parity byte.
// o_state exposes the FSM state (IDLE=0, WAIT=1, DATA=2, CHECK=3, DROP=4).
module switch_port_ctrl #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_PORTS*DATA_W-1:0]   i_port_addr,
  switch_port_ctrl_if.slave             bus,
  output logic [DATA_W-1:0]             o_addr,
  output logic                          o_parity_err,
  output logic                          o_pkt_drop,
  output logic [2:0]                    o_state
);

  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DROP  = 3'd4
  } state_t;

  state_t               r_state;
  logic [SEL_W-1:0]     r_sel;
  logic [NUM_PORTS-1:0] r_write_enb;
  logic [DATA_W-1:0]    r_data_out;
  logic [DATA_W-1:0]    r_addr;
  logic                 r_pkt_drop;
  logic                 w_match;
  logic [SEL_W-1:0]     w_match_idx;
  logic                 w_busy;
  logic                 w_data_go;

`ifdef SWITCH_PARITY_CHECK_EN
  logic [DATA_W-1:0]    r_par;
  logic                 r_parity_err;
`endif

  function automatic logic [NUM_PORTS-1:0] f_onehot(input logic [SEL_W-1:0] s);
    f_onehot    = '0;
    f_onehot[s] = 1'b1;
  endfunction

  // Header decode: lowest matching port index wins (loop runs high to low).
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (i_port_addr[i*DATA_W +: DATA_W] == bus.data_in) begin
        w_match     = 1'b1;
        w_match_idx = SEL_W'(i);
      end
    end
  end

  // In DATA a byte moves only when neither hold nor the selected FIFO stalls.
  assign w_data_go = !(bus.hold || bus.fifo_full[r_sel]);

  // Upstream stall: data_in is not consumed this cycle.
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_IDLE:  w_busy = bus.data_status && w_match && bus.fifo_full[w_match_idx];
      S_WAIT:  w_busy = bus.fifo_full[r_sel];
      S_DATA:  w_busy = !w_data_go;
      S_CHECK: w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Packet FSM with registered FIFO write strobe, data and status pulses.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_write_enb <= '0;
      r_data_out  <= '0;
      r_addr      <= '0;
      r_pkt_drop  <= 1'b0;
`ifdef SWITCH_PARITY_CHECK_EN
      r_par        <= '0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_write_enb <= '0;
      r_pkt_drop  <= 1'b0;
`ifdef SWITCH_PARITY_CHECK_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.data_status) begin
            if (!w_match) begin
              r_pkt_drop <= 1'b1;
              r_state    <= S_DROP;
            end else begin
              r_sel <= w_match_idx;
              if (bus.fifo_full[w_match_idx]) begin
                r_state <= S_WAIT;
              end else begin
                r_write_enb <= f_onehot(w_match_idx);
                r_data_out  <= bus.data_in;
                r_addr      <= bus.data_in;
`ifdef SWITCH_PARITY_CHECK_EN
                r_par       <= bus.data_in;
`endif
                r_state     <= S_DATA;
              end
            end
          end
        end
        // Header is held stable by upstream; sel was latched on entry.
        S_WAIT: begin
          if (!bus.fifo_full[r_sel]) begin
            r_write_enb <= f_onehot(r_sel);
            r_data_out  <= bus.data_in;
            r_addr      <= bus.data_in;
`ifdef SWITCH_PARITY_CHECK_EN
            r_par       <= bus.data_in;
`endif
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_data_go) begin
            r_write_enb <= f_onehot(r_sel);
            r_data_out  <= bus.data_in;
            if (bus.data_status) begin
`ifdef SWITCH_PARITY_CHECK_EN
              r_par <= r_par ^ bus.data_in;
`endif
            end else begin
`ifdef SWITCH_PARITY_CHECK_EN
              // Flag is raised so that it is visible during the CHECK cycle.
              r_parity_err <= (bus.data_in != r_par);
              r_state      <= S_CHECK;
`else
              r_state      <= S_IDLE;
`endif
            end
          end
        end
        S_CHECK: r_state <= S_IDLE;
        S_DROP: begin
          if (!bus.data_status) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.write_enb = r_write_enb;
  assign bus.data_out  = r_data_out;
  assign o_addr        = r_addr;
  assign o_pkt_drop    = r_pkt_drop;
  assign o_state       = r_state;
`ifdef SWITCH_PARITY_CHECK_EN
  assign o_parity_err  = r_parity_err;
`else
  assign o_parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_switch_port_ctrl.sv
// Testbench for switch_port_ctrl: directed packets from the test plan plus
// randomized packets, checked by a scoreboard fed from a packet-level model.
module tb_switch_port_ctrl;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int W  = NP + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  switch_port_ctrl_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

  logic [DW-1:0]    addr_tab [NP];
  logic [NP*DW-1:0] port_addr;
  logic [DW-1:0]    addr;
  logic             parity_err;
  logic             pkt_drop;
  logic [2:0]       state;

  always_comb begin
    port_addr = '0;
    for (int i = 0; i < NP; i++) port_addr[i*DW +: DW] = addr_tab[i];
  end

  switch_port_ctrl #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_port_addr  (port_addr),
    .bus          (bus),
    .o_addr       (addr),
    .o_parity_err (parity_err),
    .o_pkt_drop   (pkt_drop),
    .o_state      (state)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q [$];
  int exp_perr = 0;
  int exp_drop = 0;
  int perr_seen = 0;
  int drop_seen = 0;
  logic [DW-1:0] exp_addr = '0;

  bit rand_en = 0;
  int force_full_n = 0;
  logic [NP-1:0] force_full_mask = '0;
  int force_hold_n = 0;
  logic [DW-1:0] pl_buf [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Packet-level reference: lowest table index equal to the header, else -1.
  function automatic int route(input logic [DW-1:0] h);
    for (int i = 0; i < NP; i++) if (addr_tab[i] == h) return i;
    return -1;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp;
    if (parity_err === 1'b1) perr_seen++;
    if (pkt_drop === 1'b1) drop_seen++;
    if (!$isunknown(bus.write_enb) && bus.write_enb != '0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write: unexpected we=%b data=0x%0h", bus.write_enb, bus.data_out);
      end else begin
        exp = exp_q.pop_front();
        if ({bus.write_enb, bus.data_out} !== exp) begin
          n_fail++;
          $display("FAIL write: got we=%b data=0x%0h expected we=%b data=0x%0h",
                   bus.write_enb, bus.data_out, exp[W-1:DW], exp[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.data_status = 1'b0;
      bus.fifo_full   = '0;
      bus.hold        = 1'b0;
    end
  endtask

  // Presents one byte until it is taken; returns number of stalled cycles.
  task automatic send_byte(input logic [DW-1:0] b, input logic st, output int stalls);
    bit done = 0;
    int guard = 0;
    stalls = 0;
    while (!done) begin
      @(negedge clk);
      bus.data_in     = b;
      bus.data_status = st;
      if (force_full_n > 0) begin
        bus.fifo_full = force_full_mask;
        force_full_n--;
      end else if (rand_en) bus.fifo_full = NP'($urandom) & NP'($urandom);
      else bus.fifo_full = '0;
      if (force_hold_n > 0) begin
        bus.hold = 1'b1;
        force_hold_n--;
      end else if (rand_en) bus.hold = ($urandom_range(0, 4) == 0);
      else bus.hold = 1'b0;
      #1;
      if (!bus.busy) done = 1;
      else stalls++;
      guard++;
      if (!done && guard > 300) begin
        n_cmp++;
        n_fail++;
        $display("FAIL timeout: byte 0x%0h still stalled after %0d cycles, required accept", b, guard);
        done = 1;
      end
    end
    @(posedge clk);
  endtask

  // Sends header, len payload bytes and par_byte (only the first cut bytes).
  task automatic send_packet(input logic [DW-1:0] h, input int len, input logic [DW-1:0] pl [8],
                             input logic [DW-1:0] par_byte, input int cut, input int hold_at,
                             output int first_stall, output int total_stall);
    logic [DW-1:0] bytes [10];
    logic [DW-1:0] true_par;
    logic [NP-1:0] oh;
    int port, n, nsend, s;
    true_par = h;
    bytes[0] = h;
    for (int i = 0; i < len; i++) begin
      bytes[i+1] = pl[i];
      true_par   = true_par ^ pl[i];
    end
    bytes[len+1] = par_byte;
    n     = len + 2;
    nsend = (cut < n) ? cut : n;
    port  = route(h);
    if (port >= 0) begin
      oh = '0;
      oh[port] = 1'b1;
      for (int i = 0; i < nsend; i++) exp_q.push_back({oh, bytes[i]});
      exp_addr = h;
`ifdef SWITCH_PARITY_CHECK_EN
      if (nsend == n && par_byte != true_par) exp_perr++;
`endif
    end else begin
      exp_drop++;
    end
    first_stall = 0;
    total_stall = 0;
    for (int i = 0; i < nsend; i++) begin
      if (i == hold_at) force_hold_n = 2;
      send_byte(bytes[i], (i <= len), s);
      if (i == 0) first_stall = s;
      total_stall += s;
    end
    #1;
    check("addr_after_pkt", 32'(addr), 32'(exp_addr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset           = 1'b0;
    bus.data_status = 1'b0;
    bus.fifo_full   = '0;
    bus.hold        = 1'b0;
    @(posedge clk);
    #1;
    exp_addr = '0;
    check("rst_write_enb", 32'(bus.write_enb), 0);
    check("rst_data_out", 32'(bus.data_out), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    check("rst_pkt_drop", 32'(pkt_drop), 0);
    check("rst_state_idle", 32'(state), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fs, ts;
    logic [DW-1:0] h, p;
    int len;
    reset           = 1'b0;
    bus.data_in     = '0;
    bus.data_status = 1'b0;
    bus.fifo_full   = '0;
    bus.hold        = 1'b0;
    addr_tab[0] = 8'h40; addr_tab[1] = 8'h30; addr_tab[2] = 8'h20; addr_tab[3] = 8'h10;
    repeat (2) @(posedge clk);
    do_reset();

    // Routed packet, good parity, to port 2.
    pl_buf[0] = 8'h11; pl_buf[1] = 8'h22;
    send_packet(8'h20, 2, pl_buf, 8'h13, 99, -1, fs, ts);
    check("routed_no_stall", 32'(ts), 0);
    idle(2);
    // Same packet, wrong parity.
    send_packet(8'h20, 2, pl_buf, 8'h00, 99, -1, fs, ts);
    idle(2);
    // Unmatched header: dropped, never stalls even with random full/hold.
    rand_en = 1;
    pl_buf[0] = 8'hA1; pl_buf[1] = 8'hB2; pl_buf[2] = 8'hC3;
    send_packet(8'h55, 3, pl_buf, 8'h5A, 99, -1, fs, ts);
    check("drop_busy_never", 32'(ts), 0);
    check("drop_back_idle", 32'(state), 0);
    rand_en = 0;
    idle(2);
    // Selected FIFO full for 3 cycles at header time.
    force_full_mask = 4'b0010;
    force_full_n    = 3;
    pl_buf[0] = 8'h77;
    send_packet(8'h30, 1, pl_buf, 8'h30 ^ 8'h77, 99, -1, fs, ts);
    check("full_hdr_stall", 32'(fs), 3);
    idle(2);
    // Hold for 2 cycles on the second payload byte.
    pl_buf[0] = 8'h01; pl_buf[1] = 8'h02; pl_buf[2] = 8'h03;
    send_packet(8'h10, 3, pl_buf, 8'h10 ^ 8'h01 ^ 8'h02 ^ 8'h03, 99, 2, fs, ts);
    check("hold_stall", 32'(ts), 2);
    idle(2);
    // Reset in the middle of a payload.
    pl_buf[0] = 8'hDE; pl_buf[1] = 8'hAD;
    send_packet(8'h40, 2, pl_buf, 8'h00, 2, -1, fs, ts);
    do_reset();
    idle(1);
    // Duplicate address, back-to-back packets.
    addr_tab[0] = 8'h20;
    pl_buf[0] = 8'h5C;
    send_packet(8'h20, 1, pl_buf, 8'h20 ^ 8'h5C, 99, -1, fs, ts);
    send_packet(8'h20, 0, pl_buf, 8'h20, 99, -1, fs, ts);
`ifdef SWITCH_PARITY_CHECK_EN
    check("b2b_gap", 32'(fs), 1);
`else
    check("b2b_gap", 32'(fs), 0);
`endif
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < NP; i++) addr_tab[i] = DW'($urandom_range(0, 255));
    rand_en = 1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) < 7) h = addr_tab[$urandom_range(0, NP-1)];
      else h = DW'($urandom_range(0, 255));
      len = $urandom_range(0, 5);
      p = h;
      for (int i = 0; i < len; i++) begin
        pl_buf[i] = DW'($urandom_range(0, 255));
        p = p ^ pl_buf[i];
      end
      if ($urandom_range(0, 9) < 3) p = p ^ DW'($urandom_range(1, 255));
      send_packet(h, len, pl_buf, p, 99, -1, fs, ts);
    end
    rand_en = 0;
    idle(4);

    check("queue_drained", 32'(exp_q.size()), 0);
    check("parity_err_cycles", 32'(perr_seen), 32'(exp_perr));
    check("pkt_drop_cycles", 32'(drop_seen), 32'(exp_drop));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
